// File: rtl/window_addr_pkg.sv
// Shared types and constants for the sliding-window address generator.
// Holds the traversal state encoding and the legal kernel-size range.
// Ports: none (package only).
package window_addr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam int KSIZE_MIN = 2;
   localparam int KSIZE_MAX = 7;

   // Width of the kx/ky index counters; must hold KSIZE_MAX-1.
   localparam int KIDX_W = 3;

   function automatic bit ksize_legal(input int k);
      return (k >= KSIZE_MIN) && (k <= KSIZE_MAX);
   endfunction

endpackage

// File: rtl/window_addr_gen_if.sv
// Read/write address channels of the window address generator.
// master: drives addresses and valids, receives readies.
// slave: the memory side that accepts the addresses.
interface window_addr_gen_if #(
   parameter int ADDR_W = 32
) ();

   logic [ADDR_W-1:0] o_raddr;
   logic              o_rvalid;
   logic              i_rready;
   logic [ADDR_W-1:0] o_waddr;
   logic              o_wvalid;
   logic              i_wready;

   modport master (
      output o_raddr, o_rvalid, o_waddr, o_wvalid,
      input  i_rready, i_wready
   );

   modport slave (
      input  o_raddr, o_rvalid, o_waddr, o_wvalid,
      output i_rready, i_wready
   );

endinterface

// File: rtl/window_idx_counter.sv
// Limit-and-wrap index counter: counts 0..limit on inc, then wraps to 0.
// Ports: clk, n_rst (sync, active-high), clr, inc, limit -> value, wrap.
// wrap is combinational: high in the cycle an inc takes value from limit to 0.
module window_idx_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clr,
   input  logic             inc,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] value,
   output logic             wrap
);

   assign wrap = inc && (value == limit);

   always_ff @(posedge clk) begin
      if (n_rst) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (inc) begin
         value <= wrap ? '0 : value + WIDTH'(1);
      end
   end

endmodule

// File: rtl/window_addr_gen.sv
// Generates read addresses for every KSIZE x KSIZE window of an image (raster
// order, optional sliding reuse) and one write address per completed window.
// Ports: clk, n_rst, start/config inputs, bus (read/write channels), busy/done/err.
module window_addr_gen
   import window_addr_pkg::*;
#(
   parameter int KSIZE  = 3,
   parameter int ADDR_W = 32,
   parameter int DIM_W  = 16,
   parameter int BPP    = 1
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               i_start,
   input  logic               i_slide,
   input  logic [ADDR_W-1:0]  i_rd_base,
   input  logic [ADDR_W-1:0]  i_wr_base,
   input  logic [DIM_W-1:0]   i_img_width,
   input  logic [DIM_W-1:0]   i_img_height,
   window_addr_gen_if.master  bus,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_err
);

   localparam int  PEND_W = 2 * DIM_W;
   localparam bit  K_OK   = ksize_legal(KSIZE);

   localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(BPP);
   localparam logic [ADDR_W-1:0] K_STEP   = ADDR_W'(KSIZE * BPP);
   localparam logic [ADDR_W-1:0] KM1_STEP = ADDR_W'((KSIZE - 1) * BPP);
   localparam logic [KIDX_W-1:0] K_LIM    = KIDX_W'(KSIZE - 1);
   localparam logic [DIM_W-1:0]  K_DIM    = DIM_W'(KSIZE);

   state_t state_q, state_d;

   logic              slide_q;
   logic [DIM_W-1:0]  lim_c_q, lim_r_q;
   logic [DIM_W-1:0]  c_val, r_val;
   logic [KIDX_W-1:0] kx_val, ky_val;
   logic [ADDR_W-1:0] step_w_q, step_row_q;
   logic [ADDR_W-1:0] win_ptr_q, raddr_q, waddr_q, nxt_win;
   logic [PEND_W-1:0] pend_q;
   logic              done_q, err_q;
   logic              rvalid, wvalid;
   logic              legal, start_ok, start_bad;
   logic              rd_fire, w_fire, last_wr;
   logic              skip_kx, kx_inc, kx_wrap, row_end, ky_wrap, c_wrap, r_wrap;
   logic              idx_unused;

   assign legal     = K_OK && (i_img_width >= K_DIM) && (i_img_height >= K_DIM);
   assign start_ok  = (state_q == IDLE) && i_start && legal;
   assign start_bad = (state_q == IDLE) && i_start && !legal;

   assign rd_fire = rvalid && bus.i_rready;
   assign w_fire  = wvalid && bus.i_wready;

   // In sliding mode every window after the first of a row only fetches its
   // rightmost column; kx then stays parked and each read ends a kernel row.
   assign skip_kx = slide_q && (c_val != '0);
   assign kx_inc  = rd_fire && !skip_kx;
   assign row_end = skip_kx ? rd_fire : kx_wrap;

   // The last write is the one that drains the final pending window in FLUSH.
   assign last_wr = (state_q == FLUSH) && w_fire && (pend_q == PEND_W'(1));

   // Next window origin: one pixel right, or at the end of a row jump from
   // (r, W-K) to (r+1, 0), which is exactly K pixels further on.
   assign nxt_win = win_ptr_q + (c_wrap ? K_STEP : STEP);

   assign idx_unused = ^{kx_val, ky_val, r_val};

   window_idx_counter #(.WIDTH(KIDX_W)) u_kx (
      .clk(clk), .n_rst(n_rst), .clr(start_ok), .inc(kx_inc),
      .limit(K_LIM), .value(kx_val), .wrap(kx_wrap)
   );

   window_idx_counter #(.WIDTH(KIDX_W)) u_ky (
      .clk(clk), .n_rst(n_rst), .clr(start_ok), .inc(row_end),
      .limit(K_LIM), .value(ky_val), .wrap(ky_wrap)
   );

   window_idx_counter #(.WIDTH(DIM_W)) u_c (
      .clk(clk), .n_rst(n_rst), .clr(start_ok), .inc(ky_wrap),
      .limit(lim_c_q), .value(c_val), .wrap(c_wrap)
   );

   window_idx_counter #(.WIDTH(DIM_W)) u_r (
      .clk(clk), .n_rst(n_rst), .clr(start_ok), .inc(c_wrap),
      .limit(lim_r_q), .value(r_val), .wrap(r_wrap)
   );

   always_ff @(posedge clk) begin
      if (n_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_ok)           state_d = RUN;
         RUN:     if (rd_fire && r_wrap)  state_d = FLUSH;
         FLUSH:   if (last_wr)            state_d = IDLE;
         default:                         state_d = IDLE;
      endcase
   end

   always_comb begin
      rvalid = (state_q == RUN);
      wvalid = (state_q != IDLE) && (pend_q != '0);
      o_busy = (state_q != IDLE);
   end

   assign bus.o_rvalid = rvalid;
   assign bus.o_wvalid = wvalid;
   assign bus.o_raddr  = raddr_q;
   assign bus.o_waddr  = waddr_q;
   assign o_done       = done_q;
   assign o_err        = err_q;

   always_ff @(posedge clk) begin
      if (n_rst) begin
         slide_q    <= 1'b0;
         lim_c_q    <= '0;
         lim_r_q    <= '0;
         step_w_q   <= '0;
         step_row_q <= '0;
         win_ptr_q  <= '0;
         raddr_q    <= '0;
         waddr_q    <= '0;
         pend_q     <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         done_q <= last_wr;
         err_q  <= start_bad;
         if (start_ok) begin
            slide_q    <= i_slide;
            lim_c_q    <= i_img_width - K_DIM;
            lim_r_q    <= i_img_height - K_DIM;
            // Strides are formed once here so the per-address path is adders only.
            step_w_q   <= ADDR_W'(i_img_width) * STEP;
            step_row_q <= ADDR_W'(i_img_width - K_DIM + DIM_W'(1)) * STEP;
            win_ptr_q  <= i_rd_base;
            raddr_q    <= i_rd_base;
            waddr_q    <= i_wr_base;
            pend_q     <= '0;
         end else begin
            if (rd_fire) begin
               if (ky_wrap) begin
                  win_ptr_q <= nxt_win;
                  // A sliding window that is not at column 0 starts on its last column.
                  raddr_q   <= (slide_q && !c_wrap) ? nxt_win + KM1_STEP : nxt_win;
               end else if (row_end) begin
                  raddr_q <= raddr_q + (skip_kx ? step_w_q : step_row_q);
               end else begin
                  raddr_q <= raddr_q + STEP;
               end
            end
            if (w_fire) waddr_q <= waddr_q + STEP;
            // Window completions and write acceptances in the same cycle both count.
            pend_q <= pend_q + PEND_W'(ky_wrap) - PEND_W'(w_fire);
         end
      end
   end

endmodule

// File: tb/tb_window_addr_gen.sv
// Directed bench for window_addr_gen (K=3, 32-bit addresses, BPP=1).
// Ports: none; drives the DUT through a window_addr_gen_if instance.
// Expected addresses come from a nested-loop reference of the window order.
module tb_window_addr_gen;

   logic        clk = 1'b0;
   logic        n_rst, i_start, i_slide;
   logic [31:0] i_rd_base, i_wr_base;
   logic [15:0] i_img_width, i_img_height;
   logic        o_busy, o_done, o_err;

   always #5 clk = ~clk;

   window_addr_gen_if #(.ADDR_W(32)) bus ();

   window_addr_gen #(.KSIZE(3), .ADDR_W(32), .DIM_W(16), .BPP(1)) dut (
      .clk(clk), .n_rst(n_rst), .i_start(i_start), .i_slide(i_slide),
      .i_rd_base(i_rd_base), .i_wr_base(i_wr_base),
      .i_img_width(i_img_width), .i_img_height(i_img_height),
      .bus(bus), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
   );

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] got_r[$], got_w[$], exp_r[$], exp_w[$];
   int          win_end[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic build_model(input int w, input int h, input bit slide,
                              input logic [31:0] rb, input logic [31:0] wb);
      exp_r.delete(); exp_w.delete(); win_end.delete();
      for (int r = 0; r <= h - 3; r++)
         for (int c = 0; c <= w - 3; c++) begin
            for (int ky = 0; ky < 3; ky++)
               for (int kx = 0; kx < 3; kx++)
                  if (!(slide && c > 0 && kx != 2))
                     exp_r.push_back(rb + 32'((r + ky) * w + c + kx));
            win_end.push_back(exp_r.size());
            exp_w.push_back(wb + 32'(exp_w.size()));
         end
   endtask

   task automatic run_traversal(input string tag, input int w, input int h, input bit slide,
                                input logic [31:0] rb, input logic [31:0] wb, input bit bp);
      int          done_cnt = 0, err_cnt = 0, post = 0, last_w_cyc = -10;
      logic        stall_r = 1'b0, stall_w = 1'b0;
      logic [31:0] held_r = '0, held_w = '0;
      build_model(w, h, slide, rb, wb);
      got_r.delete(); got_w.delete();
      @(negedge clk);
      i_rd_base = rb; i_wr_base = wb; i_img_width = 16'(w); i_img_height = 16'(h);
      i_slide = slide; i_start = 1'b1; bus.i_rready = 1'b1; bus.i_wready = 1'b1;
      @(negedge clk);
      check({tag, " rvalid after start"}, 32'(bus.o_rvalid), 32'd1);
      check({tag, " first raddr"}, bus.o_raddr, rb);
      check({tag, " busy"}, 32'(o_busy), 32'd1);
      // Scrambled config and a start while busy must both be ignored.
      i_rd_base = ~rb; i_img_width = 16'd9; i_img_height = 16'd9; i_slide = ~slide;
      for (int cyc = 0; cyc < 4000 && post < 3; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (cyc == 1) i_start = 1'b0;
         bus.i_rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.i_wready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stall_r) begin
            check({tag, " rvalid held"}, 32'(bus.o_rvalid), 32'd1);
            check({tag, " raddr held"}, bus.o_raddr, held_r);
         end
         if (stall_w) begin
            check({tag, " wvalid held"}, 32'(bus.o_wvalid), 32'd1);
            check({tag, " waddr held"}, bus.o_waddr, held_w);
         end
         if (bus.o_wvalid) begin
            if (got_w.size() < win_end.size())
               check({tag, " write after window"},
                     32'(got_r.size() >= win_end[got_w.size()]), 32'd1);
            else
               check({tag, " write count"}, 32'(got_w.size()), 32'(win_end.size() - 1));
         end
         if (o_done) begin
            done_cnt++;
            check({tag, " done timing"}, 32'(cyc), 32'(last_w_cyc + 1));
            check({tag, " busy at done"}, 32'(o_busy), 32'd0);
         end
         if (o_err) err_cnt++;
         stall_r = bus.o_rvalid && !bus.i_rready;
         stall_w = bus.o_wvalid && !bus.i_wready;
         held_r  = bus.o_raddr;
         held_w  = bus.o_waddr;
         if (bus.o_rvalid && bus.i_rready) got_r.push_back(bus.o_raddr);
         if (bus.o_wvalid && bus.i_wready) begin
            got_w.push_back(bus.o_waddr);
            last_w_cyc = cyc;
         end
         if (done_cnt > 0) post++;
      end
      bus.i_rready = 1'b1; bus.i_wready = 1'b1;
      check({tag, " done count"}, 32'(done_cnt), 32'd1);
      check({tag, " err count"}, 32'(err_cnt), 32'd0);
      check({tag, " read count"}, 32'(got_r.size()), 32'(exp_r.size()));
      check({tag, " write count"}, 32'(got_w.size()), 32'(exp_w.size()));
      for (int i = 0; i < exp_r.size() && i < got_r.size(); i++)
         check($sformatf("%s raddr[%0d]", tag, i), got_r[i], exp_r[i]);
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
         check($sformatf("%s waddr[%0d]", tag, i), got_w[i], exp_w[i]);
   endtask

   task automatic check_first_window(input string tag);
      logic [31:0] hand[9];
      hand = '{32'h100, 32'h101, 32'h102, 32'h105, 32'h106, 32'h107, 32'h10A, 32'h10B, 32'h10C};
      check({tag, " reads total"}, 32'(got_r.size()), 32'd54);
      for (int i = 0; i < 9; i++)
         if (i < got_r.size()) check($sformatf("%s win0[%0d]", tag, i), got_r[i], hand[i]);
      if (got_w.size() == 6) check({tag, " last waddr"}, got_w[5], 32'h2005);
      else check({tag, " writes total"}, 32'(got_w.size()), 32'd6);
   endtask

   initial begin
      int          seen;
      logic [31:0] wrap_hand[9];

      n_rst = 1'b1; i_start = 1'b0; i_slide = 1'b0;
      i_rd_base = '0; i_wr_base = '0; i_img_width = '0; i_img_height = '0;
      bus.i_rready = 1'b0; bus.i_wready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset raddr", bus.o_raddr, 32'd0);
      check("reset rvalid", 32'(bus.o_rvalid), 32'd0);
      check("reset waddr", bus.o_waddr, 32'd0);
      check("reset wvalid", 32'(bus.o_wvalid), 32'd0);
      check("reset busy", 32'(o_busy), 32'd0);
      check("reset done", 32'(o_done), 32'd0);
      check("reset err", 32'(o_err), 32'd0);
      n_rst = 1'b0;

      // Full windows, no stalls.
      run_traversal("full", 5, 4, 1'b0, 32'h100, 32'h2000, 1'b0);
      check_first_window("full");

      // Sliding reuse, no stalls.
      run_traversal("slide", 5, 4, 1'b1, 32'h100, 32'h2000, 1'b0);
      check("slide reads total", 32'(got_r.size()), 32'd30);
      if (got_r.size() >= 12) begin
         check("slide win01[0]", got_r[9], 32'h103);
         check("slide win01[1]", got_r[10], 32'h108);
         check("slide win01[2]", got_r[11], 32'h10D);
      end

      // Random backpressure on both channels.
      run_traversal("full_bp", 5, 4, 1'b0, 32'h100, 32'h2000, 1'b1);
      check_first_window("full_bp");
      run_traversal("slide_bp", 5, 4, 1'b1, 32'h100, 32'h2000, 1'b1);
      run_traversal("big_bp", 7, 6, 1'b1, 32'h4000, 32'h8000, 1'b1);

      // Illegal geometry: narrow image.
      @(negedge clk);
      i_img_width = 16'd2; i_img_height = 16'd5; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      check("err pulse", 32'(o_err), 32'd1);
      check("err busy", 32'(o_busy), 32'd0);
      check("err rvalid", 32'(bus.o_rvalid), 32'd0);
      seen = 0;
      @(negedge clk);
      check("err one cycle", 32'(o_err), 32'd0);
      repeat (3) begin
         if (o_busy || bus.o_rvalid || o_done) seen++;
         @(negedge clk);
      end
      check("err stays idle", 32'(seen), 32'd0);

      // Reset in the middle of a traversal, together with a start.
      i_rd_base = 32'h100; i_wr_base = 32'h2000; i_img_width = 16'd5; i_img_height = 16'd4;
      i_slide = 1'b0; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (8) @(negedge clk);
      check("midrun busy", 32'(o_busy), 32'd1);
      n_rst = 1'b1; i_start = 1'b1;
      @(negedge clk);
      check("rst raddr", bus.o_raddr, 32'd0);
      check("rst rvalid", 32'(bus.o_rvalid), 32'd0);
      check("rst waddr", bus.o_waddr, 32'd0);
      check("rst wvalid", 32'(bus.o_wvalid), 32'd0);
      check("rst busy", 32'(o_busy), 32'd0);
      check("rst done", 32'(o_done), 32'd0);
      check("rst err", 32'(o_err), 32'd0);
      n_rst = 1'b0; i_start = 1'b0;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (o_done || o_err || o_busy) seen++;
      end
      check("post-reset quiet", 32'(seen), 32'd0);
      run_traversal("restart", 5, 4, 1'b0, 32'h100, 32'h2000, 1'b0);
      check_first_window("restart");

      // Address wrap at the top of the 32-bit space.
      run_traversal("wrap", 3, 3, 1'b0, 32'hFFFF_FFFE, 32'h10, 1'b0);
      wrap_hand = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h2, 32'h3,
                    32'h4, 32'h5, 32'h6};
      check("wrap reads total", 32'(got_r.size()), 32'd9);
      for (int i = 0; i < 9; i++)
         if (i < got_r.size()) check($sformatf("wrap hand[%0d]", i), got_r[i], wrap_hand[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/window_addr_gen.md
WINDOW_ADDR_GEN -- requirements
Module: window_addr_gen

Interface
REQ-001 Parameter KSIZE, default 3: kernel edge length, legal range 2..7.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DIM_W, default 16: image dimension width.
REQ-004 Parameter BPP, default 1: bytes per pixel, used as the address step.
REQ-005 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on the rising edge.
- n_rst  in  1  synchronous, active-high reset; asserted = 1.
- i_start  in  1  start pulse; sampled in IDLE only.
- i_slide  in  1  sliding-reuse mode select; latched at start.
- i_rd_base  in  ADDR_W  source image base address.
- i_wr_base  in  ADDR_W  destination image base address.
- i_img_width, i_img_height  in  DIM_W  image dimensions W and H.
- o_raddr  out  ADDR_W  read address.
- o_rvalid  out  1  read address valid.
- i_rready  in  1  read address accepted.
- o_waddr  out  ADDR_W  write address.
- o_wvalid  out  1  write address valid.
- i_wready  in  1  write address accepted.
- o_busy  out  1  traversal in progress.
- o_done  out  1  one-cycle pulse on completion.
- o_err  out  1  one-cycle pulse on illegal configuration.

Function
REQ-006 States: IDLE, RUN, FLUSH. IDLE->RUN on i_start with W>=KSIZE and H>=KSIZE. RUN->FLUSH when the last read is accepted. FLUSH->IDLE when the last write is accepted.
REQ-007 i_start with W<KSIZE or H<KSIZE SHALL pulse o_err the next cycle and remain in IDLE.
REQ-008 At start, the block SHALL latch bases, W, H and i_slide; input changes during RUN or FLUSH have no effect.
REQ-009 Window origin (r,c) SHALL traverse raster order, r in 0..H-KSIZE and c in 0..W-KSIZE.
REQ-010 Per window, reads SHALL issue row-major over ky,kx in 0..KSIZE-1, with address rd_base+((r+ky)*W+(c+kx))*BPP.
REQ-011 With slide=1 and c>0, a window SHALL issue only the kx=KSIZE-1 column, in ky order; c=0 issues the full KSIZE*KSIZE set.
REQ-012 The window write address SHALL be wr_base+(r*(W-KSIZE+1)+c)*BPP.
REQ-013 o_rvalid SHALL rise the cycle after accepted i_start; a transfer occurs when o_rvalid&i_rready; o_raddr SHALL hold stable while o_rvalid&!i_rready.
REQ-014 When accepted reads are continuous, the read stream SHALL sustain one address per cycle with no bubbles at row or window boundaries.
REQ-015 o_wvalid SHALL assert only while writes accepted < windows completed, where a window completes when its final read is accepted; writes never lead reads.
REQ-016 o_waddr SHALL hold stable while o_wvalid&!i_wready.
REQ-017 A read completion and a write acceptance in the same cycle SHALL both be counted.
REQ-018 o_done SHALL pulse the cycle after the final write is accepted, coincident with the return to IDLE.
REQ-019 o_busy SHALL be 1 in RUN and FLUSH.
REQ-020 i_start while busy SHALL be ignored.
REQ-021 Address arithmetic SHALL be unsigned modulo 2^ADDR_W and use incremental adders (pointer + step), not per-address multipliers.

Reset
REQ-022 With n_rst=1 at a clock edge, the block SHALL enter IDLE, clear all counters, and drive every output to 0 on the next cycle.
REQ-023 Reset SHALL override any in-flight traversal, with no o_done or o_err pulse.
REQ-024 Reset SHALL take precedence over a simultaneous i_start.

Structure
REQ-025 Package window_addr_pkg SHALL hold the state enum (IDLE, RUN, FLUSH) and the KSIZE legality constants.
REQ-026 Sub-module window_idx_counter SHALL implement a limit-and-wrap counter (inc, limit, value, wrap), instanced for kx, ky, c and r.
REQ-027 The implementation SHALL be 120-400 lines of RTL.

Verification
REQ-028 W=5, H=4, K=3, slide=0, rd_base=0x100, i_rready=1: 54 reads; first window 0x100,101,102,105,106,107,10A,10B,10C; writes wr_base+0..5; o_done once.
REQ-029 Same image, slide=1: 30 reads; window (0,1) issues 0x103,0x108,0x10D only.
REQ-030 Random i_rready/i_wready backpressure: addresses held while stalled; identical address sequences to the no-stall run; no write before its window completes.
REQ-031 W=2, H=5, K=3: o_err pulses one cycle later; o_rvalid, o_busy and o_done stay 0.
REQ-032 n_rst=1 asserted mid-RUN, then i_start: all outputs 0 the cycle after reset; restart reproduces the REQ-028 sequence from 0x100.
REQ-033 rd_base=0xFFFFFFFE, W=H=3: the block wraps modulo 2^32 to 0x00000000 without error.
